// File: rtl/selector_scan_pkg.sv
// selector_pkg: shared constants and helpers for the selector_scan slice.
//   MODE_MANUAL / MODE_SCAN : encodings of the iMode input.
//   ch_idx_t                : generic channel index, wide enough for any
//                             channel count a sibling block is built with.
//   clog2()                 : constant-evaluable ceiling log2, minimum 1, so
//                             a two-channel selector still gets a 1-bit select.
package selector_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_IDX_BITS = 8;
    typedef logic [MAX_IDX_BITS-1:0] ch_idx_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/selector_scan_next_ch.sv
// scan_next_ch: combinational search for the next enabled channel.
//   cur     : index currently selected
//   mask    : 1 = channel may be visited
//   next_ch : first enabled index searched cyclically from cur+1; falls back
//             to cur itself when cur is the only enabled channel
//   wrap    : next_ch <= cur (the search went past CHANNELS-1 or stayed put)
//   any_en  : at least one mask bit set; next_ch is meaningless when 0
module scan_next_ch
    import selector_pkg::*;
#(
    parameter int CHANNELS = 8,
    localparam int SW = clog2(CHANNELS)
) (
    input  logic [SW-1:0]       cur,
    input  logic [CHANNELS-1:0] mask,
    output logic [SW-1:0]       next_ch,
    output logic                wrap,
    output logic                any_en
);

    logic found;
    logic [SW-1:0] idx;

    always_comb begin
        next_ch = cur;
        found   = 1'b0;
        idx     = '0;
        // k runs 1..CHANNELS so that cur itself is the last candidate.
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = SW'((int'(cur) + k) % CHANNELS);
            if (!found && mask[idx]) begin
                found   = 1'b1;
                next_ch = idx;
            end
        end
        wrap   = (next_ch <= cur);
        any_en = |mask;
    end

endmodule

// File: rtl/selector_scan.sv
// selector_scan: N-channel, W-bit registered selector with manual and
// auto-scan modes.
//   iClk    : clock, all state updates on the rising edge
//   iRst    : synchronous active-high reset, wins over every other input
//   iData   : packed channels, channel k = iData[k*WIDTH +: WIDTH]
//   iSel    : manual select; values >= CHANNELS leave the channel unchanged
//   iMode   : MODE_MANUAL / MODE_SCAN
//   iHold   : scan only, freezes dwell counter and channel
//   iMask   : scan only, 1 = channel visited
//   oZ      : registered data of the selected channel (0 when not valid)
//   oCh     : index of the channel in oZ
//   oOneHot : one-hot of oCh, all zero when oValid = 0
//   oValid  : oZ holds a legitimately selected channel
//   oWrap   : one-cycle pulse after a scan advance to a lower or equal index
// All outputs are registers; inputs only reach them through ch_next.
module selector_scan
    import selector_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int DIV      = 4,
    localparam int SW = clog2(CHANNELS),
    localparam int CW = clog2(DIV)
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [CHANNELS*WIDTH-1:0] iData,
    input  logic [SW-1:0]             iSel,
    input  logic                      iMode,
    input  logic                      iHold,
    input  logic [CHANNELS-1:0]       iMask,
    output logic [WIDTH-1:0]          oZ,
    output logic [SW-1:0]             oCh,
    output logic [CHANNELS-1:0]       oOneHot,
    output logic                      oValid,
    output logic                      oWrap
);

    logic [SW-1:0]       ch, ch_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic                valid_next, wrap_next;
    logic [WIDTH-1:0]    z_next;
    logic [CHANNELS-1:0] onehot_next;

    logic [SW-1:0] scan_ch;
    logic          scan_wrap;
    logic          scan_any;

    scan_next_ch #(.CHANNELS(CHANNELS)) u_next (
        .cur     (ch),
        .mask    (iMask),
        .next_ch (scan_ch),
        .wrap    (scan_wrap),
        .any_en  (scan_any)
    );

    // Next channel / dwell counter. Entering scan from manual needs no extra
    // state: manual keeps cnt at 0, so the current channel gets a full dwell.
    always_comb begin
        ch_next    = ch;
        cnt_next   = cnt;
        valid_next = 1'b1;
        wrap_next  = 1'b0;
        if (iMode == MODE_MANUAL) begin
            if (int'(iSel) < CHANNELS) begin
                ch_next = iSel;
            end
            cnt_next = '0;
        end else if (!scan_any) begin
            valid_next = 1'b0;
        end else if (!iHold) begin
            if (cnt == CW'(DIV - 1)) begin
                cnt_next  = '0;
                ch_next   = scan_ch;
                wrap_next = scan_wrap;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Output mux and one-hot decode from ch_next, gated by validity.
    always_comb begin
        z_next      = '0;
        onehot_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_next == SW'(k)) begin
                if (valid_next) begin
                    z_next = iData[k*WIDTH +: WIDTH];
                end
                onehot_next[k] = valid_next;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ch      <= '0;
            cnt     <= '0;
            oZ      <= '0;
            oCh     <= '0;
            oOneHot <= '0;
            oValid  <= 1'b0;
            oWrap   <= 1'b0;
        end else begin
            ch      <= ch_next;
            cnt     <= cnt_next;
            oZ      <= z_next;
            oCh     <= ch_next;
            oOneHot <= onehot_next;
            oValid  <= valid_next;
            oWrap   <= wrap_next;
        end
    end

endmodule

// File: tb/tb_selector_scan.sv
// Bench for selector_scan: two instances (8 channels / dwell 3, and
// 6 channels / dwell 1) driven from one directed-then-random sequence and
// compared every cycle against a behavioural model of the selection rules.
module tb_selector_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mode, hold;

    logic [31:0] data_a;
    logic [2:0]  sel_a;
    logic [7:0]  mask_a;
    logic [3:0]  za;
    logic [2:0]  cha;
    logic [7:0]  oha;
    logic        va, wa;

    logic [23:0] data_b;
    logic [2:0]  sel_b;
    logic [5:0]  mask_b;
    logic [3:0]  zb;
    logic [2:0]  chb;
    logic [5:0]  ohb;
    logic        vb, wb;

    selector_scan #(.WIDTH(4), .CHANNELS(8), .DIV(3)) dut_a (
        .iClk(clk), .iRst(rst), .iData(data_a), .iSel(sel_a), .iMode(mode),
        .iHold(hold), .iMask(mask_a), .oZ(za), .oCh(cha), .oOneHot(oha),
        .oValid(va), .oWrap(wa)
    );

    selector_scan #(.WIDTH(4), .CHANNELS(6), .DIV(1)) dut_b (
        .iClk(clk), .iRst(rst), .iData(data_b), .iSel(sel_b), .iMode(mode),
        .iHold(hold), .iMask(mask_b), .oZ(zb), .oCh(chb), .oOneHot(ohb),
        .oValid(vb), .oWrap(wb)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: current channel and cycles spent in its dwell.
    int m_ch[2];
    int m_cnt[2];
    int e_z[2], e_ch[2], e_oh[2], e_v[2], e_w[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int id, input int nc, input int dv,
                         input logic [31:0] data, input int sel, input logic [31:0] mask);
        int nxt;
        e_w[id] = 0;
        e_v[id] = 1;
        if (rst) begin
            m_ch[id]  = 0;
            m_cnt[id] = 0;
            e_v[id]   = 0;
        end else if (!mode) begin
            if (sel < nc) m_ch[id] = sel;
            m_cnt[id] = 0;
        end else if (mask == 0) begin
            e_v[id] = 0;
        end else if (!hold) begin
            if (m_cnt[id] < dv - 1) begin
                m_cnt[id]++;
            end else begin
                m_cnt[id] = 0;
                nxt = m_ch[id];
                for (int k = 1; k <= nc; k++) begin
                    if (mask[(m_ch[id] + k) % nc]) begin
                        nxt = (m_ch[id] + k) % nc;
                        break;
                    end
                end
                e_w[id] = (nxt <= m_ch[id]) ? 1 : 0;
                m_ch[id] = nxt;
            end
        end
        e_ch[id] = m_ch[id];
        e_z[id]  = e_v[id] ? int'((data >> (4 * m_ch[id])) & 32'hF) : 0;
        e_oh[id] = e_v[id] ? (1 << m_ch[id]) : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model(0, 8, 3, data_a, int'(sel_a), {24'b0, mask_a});
        model(1, 6, 1, {8'b0, data_b}, int'(sel_b), {26'b0, mask_b});
        #1;
        chk("a_z",  {28'b0, za},  e_z[0]);
        chk("a_ch", {29'b0, cha}, e_ch[0]);
        chk("a_oh", {24'b0, oha}, e_oh[0]);
        chk("a_v",  {31'b0, va},  e_v[0]);
        chk("a_w",  {31'b0, wa},  e_w[0]);
        chk("b_z",  {28'b0, zb},  e_z[1]);
        chk("b_ch", {29'b0, chb}, e_ch[1]);
        chk("b_oh", {26'b0, ohb}, e_oh[1]);
        chk("b_v",  {31'b0, vb},  e_v[1]);
        chk("b_w",  {31'b0, wb},  e_w[1]);
    endtask

    initial begin
        // Reset with nonzero data and scan mode requested.
        rst = 1'b1; mode = 1'b1; hold = 1'b0;
        data_a = 32'h8765_4321; data_b = 24'h65_4321;
        sel_a = 3'd0; sel_b = 3'd0;
        mask_a = 8'hFF; mask_b = 6'h3F;
        step();
        step();
        chk("rst_a_z", {28'b0, za}, 32'h0);
        chk("rst_a_oh", {24'b0, oha}, 32'h0);
        chk("rst_a_v", {31'b0, va}, 32'h0);

        // Release: first cycle already shows channel 0 valid.
        rst = 1'b0;
        step();
        chk("rel_a_ch", {29'b0, cha}, 32'd0);
        chk("rel_a_v", {31'b0, va}, 32'd1);

        // Manual selection and out-of-range select on the 6-channel part.
        mode = 1'b0; sel_a = 3'd5; sel_b = 3'd3;
        step();
        chk("man_a_z", {28'b0, za}, 32'h6);
        chk("man_a_ch", {29'b0, cha}, 32'd5);
        chk("man_a_oh", {24'b0, oha}, 32'h20);
        sel_b = 3'd7;
        step();
        chk("oor_b_ch", {29'b0, chb}, 32'd3);
        sel_b = 3'd6;
        step();
        chk("oor6_b_ch", {29'b0, chb}, 32'd3);

        // Full scan with all channels enabled.
        mode = 1'b1;
        for (int i = 0; i < 30; i++) step();

        // Mask skipping on the dwell-1 part, then a single enabled channel.
        mask_b = 6'b10_0101;
        for (int i = 0; i < 8; i++) step();
        mask_b = 6'b00_0100;
        step();
        step();
        chk("single_b_ch", {29'b0, chb}, 32'd2);
        chk("single_b_w", {31'b0, wb}, 32'd1);

        // Hold mid-dwell.
        step();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) step();
        hold = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Empty mask.
        mask_a = 8'h00;
        for (int i = 0; i < 3; i++) step();
        chk("empty_a_v", {31'b0, va}, 32'd0);
        chk("empty_a_z", {28'b0, za}, 32'd0);
        chk("empty_a_oh", {24'b0, oha}, 32'd0);
        mask_a = 8'h10;
        for (int i = 0; i < 4; i++) step();

        // Reset in the middle of channel 3's dwell.
        mask_a = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            if (m_ch[0] == 3 && m_cnt[0] == 1) break;
            step();
        end
        chk("mid_a_ch", {29'b0, cha}, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_a_ch1", {29'b0, cha}, 32'd0);
        step();
        chk("post_rst_a_ch2", {29'b0, cha}, 32'd0);
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            mode   = ($urandom_range(0, 9) < 7);
            hold   = ($urandom_range(0, 4) == 0);
            sel_a  = 3'($urandom_range(0, 7));
            sel_b  = 3'($urandom_range(0, 7));
            data_a = $urandom;
            data_b = 24'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                mask_a = 8'h00;
                mask_b = 6'h00;
            end else if ($urandom_range(0, 3) == 0) begin
                mask_a = 8'(1 << $urandom_range(0, 7));
                mask_b = 6'(1 << $urandom_range(0, 5));
            end else if ($urandom_range(0, 3) != 0) begin
                mask_a = 8'($urandom);
                mask_b = 6'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/selector_scan.md
# selector_scan

Parametrised N-channel, W-bit registered selector with two modes: manual (channel taken from a select input) and auto-scan (channels visited in turn, each held for a fixed dwell time, masked channels skipped). It generalises the lab's fixed 4-channel combinational selector. It sits between multi-source data (counters, switch banks, BCD digits) and a single shared consumer such as a time-multiplexed seven-segment display driver.

## Interface
- WIDTH, 4, bits per channel (≥1)
- CHANNELS, 8, number of input channels (≥2)
- DIV, 4, dwell in clock cycles per channel in scan mode (≥1)
- SW = $clog2(CHANNELS), derived select width (localparam)

- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  reset, synchronous, active-high
- iData  in  CHANNELS*WIDTH  packed inputs; channel k = iData[k*WIDTH +: WIDTH]
- iSel  in  SW  manual channel select
- iMode  in  1  0 = manual, 1 = scan
- iHold  in  1  scan mode: freeze dwell counter and channel
- iMask  in  CHANNELS  scan mode: 1 = channel enabled for visiting
- oZ  out  WIDTH  selected data, registered
- oCh  out  SW  index of channel currently in oZ
- oOneHot  out  CHANNELS  one-hot of oCh; all-zero when oValid=0
- oValid  out  1  oZ holds a legitimately selected channel
- oWrap  out  1  one-cycle pulse when scan wraps back to a lower or equal index

## Operation
- State: ch (SW bits), cnt (dwell counter, 0..DIV-1), all outputs registered.
- Reset (iRst=1 at an edge): ch=0, cnt=0, oZ=0, oCh=0, oOneHot=0, oValid=0, oWrap=0. Reset wins over every other input, including mid-dwell.
- Manual (iMode=0): ch_next = iSel if iSel < CHANNELS, else ch unchanged. iMask and iHold ignored. cnt held at 0. oValid=1.
- Scan (iMode=1), iMask≠0:
  - iHold=1: cnt and ch frozen.
  - iHold=0, cnt<DIV-1: cnt+1, ch unchanged.
  - iHold=0, cnt==DIV-1: cnt=0; ch_next = first index with iMask=1 searched cyclically from ch+1 (wraps CHANNELS-1 → 0; may return ch itself if it is the only enabled channel).
  - oWrap=1 for the cycle after an advance with ch_next ≤ ch; otherwise 0.
  - A current channel de-masked mid-dwell stays selected until its dwell ends; oValid stays 1.
- Scan, iMask==0: ch and cnt held, oValid=0, oZ=0, oOneHot=0, oWrap=0.
- Mode change manual→scan: cnt restarts at 0, scan begins from current ch (full dwell on it). Scan→manual: ch_next=iSel that edge; cnt forced to 0.
- Output stage each edge: oCh<=ch_next; oZ<=channel ch_next of iData (or 0 if invalid); oOneHot<=1<<ch_next gated by validity.

## Timing
- Latency 1 cycle: iSel/iData/iMask sampled at edge t appear on outputs immediately after edge t.
- Dwell: in scan with iHold=0, each visited channel occupies oCh for exactly DIV consecutive cycles; DIV=1 advances every cycle.
- iHold asserted for H cycles extends the current dwell by exactly H cycles.
- First cycle after reset release: outputs reflect the mode/inputs sampled at that edge (oValid may rise then).
- No combinational path from any input to any output.

## Structure
- Shared package selector_pkg: MODE_MANUAL=1'b0, MODE_SCAN=1'b1 constants; ch_idx_t typedef helper and clog2 utility used by sibling blocks.
- One sub-module: scan_next_ch (combinational, parameter CHANNELS): inputs current index and mask, outputs next enabled index, wrap flag, and any-enabled flag. Top module holds cnt, ch and output registers.

## Test plan
- Reset: drive iRst=1 with iData nonzero, iMode=1 → all outputs 0 next cycle; release → oCh=0, oValid=1 with iMask=8'hFF.
- Manual: CHANNELS=8, WIDTH=4, iData channel k = k+1, iSel=5 → next cycle oZ=4'h6, oCh=5, oOneHot=8'b0010_0000; iSel out of range (CHANNELS=6, iSel=7) → oCh unchanged.
- Scan dwell/wrap: DIV=3, iMask=8'hFF → oCh 0,0,0,1,1,1,…,7,7,7,0; oWrap high exactly the cycle oCh returns to 0.
- Mask skip: iMask=8'b1000_0101, DIV=1 → oCh sequence 0,2,7,0,2,…; oWrap on each 7→0; iMask=8'b0000_0100 → oCh stays 2 with oWrap pulse every advance.
- Hold and empty mask: DIV=2, iHold high 4 cycles mid-dwell → dwell lasts 6 cycles; iMask=0 → oValid=0, oZ=0, oOneHot=0 until a bit is set.
- Reset mid-scan: iRst at cnt=1 on channel 3 → oCh=0, cnt=0; subsequent channel 0 dwell lasts full DIV cycles.
